steer_ramp_quad: RTL



---
 rtl/steer_pkg.sv | 19 +
 rtl/quad_phase.sv | 29 ++
 rtl/steer_ramp_quad.sv | 120 ++++++++++++
 3 files changed

// File: rtl/steer_pkg.sv
// Shared types and constants for the ramped quadrature steering driver.
// Holds the FSM states, the gray phase table and the clkdiv floor.
package steer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [15:0] CLKDIV_MIN = 16'd4;

    // Index 0..3 walks A,B as 00 -> 01 -> 11 -> 10 (right-hand order).
    localparam logic [3:0][1:0] GRAY_TBL = {2'b10, 2'b11, 2'b01, 2'b00};

    function automatic logic [1:0] gray_at(input logic [1:0] idx);
        return GRAY_TBL[idx];
    endfunction

endpackage

// File: rtl/quad_phase.sv
// Two-bit gray up/down phase register driving the A,B quadrature pair.
// Moves one table position per step pulse; output is registered.
module quad_phase
    import steer_pkg::*;
(
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       step,
    input  logic       up,
    output logic [1:0] ab
);

    logic [1:0] idx;
    logic [1:0] idx_nxt;

    assign idx_nxt = up ? idx + 2'd1 : idx - 2'd1;

    // Advance the table index and the registered A,B value on each step.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            idx <= 2'd0;
            ab  <= 2'b00;
        end else if (step) begin
            idx <= idx_nxt;
            ab  <= gray_at(idx_nxt);
        end
    end

endmodule

// File: rtl/steer_ramp_quad.sv
// Steering request to quadrature converter with an accelerating step rate.
// Period starts at clkdiv_eff and shrinks per step down to a floor.
module steer_ramp_quad
    import steer_pkg::*;
#(
    parameter int unsigned STEP_SHIFT = 3,
    parameter int unsigned MIN_SHIFT  = 2,
    parameter bit          ACCEL_EN   = 1'b1
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic [15:0] clkdiv,
    input  logic        right,
    input  logic        left,
    output logic [1:0]  steer,
    output logic        moving,
    output logic        dir
);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  req_q;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [15:0] period;
    logic [15:0] period_nxt;
    logic [15:0] eff_q;
    logic [15:0] eff_nxt;
    logic        dir_nxt;
    logic        step;

    logic [15:0] clkdiv_eff;
    logic [15:0] dec;
    logic [15:0] flr;
    logic [15:0] flr_nz;
    logic [15:0] ramp;
    logic        req_right;
    logic        req_left;
    logic        req_one;

    assign req_right  = (req_q == 2'b10);
    assign req_left   = (req_q == 2'b01);
    assign req_one    = req_right | req_left;
    assign clkdiv_eff = (clkdiv < CLKDIV_MIN) ? CLKDIV_MIN : clkdiv;

    // Ramp arithmetic works from the divider latched at RUN entry.
    // A zero floor would wrap cnt, so the floor never drops below 1.
    assign dec    = eff_q >> STEP_SHIFT;
    assign flr    = eff_q >> MIN_SHIFT;
    assign flr_nz = (flr == 16'd0) ? 16'd1 : flr;
    assign ramp   = ({1'b0, period} >= ({1'b0, flr_nz} + {1'b0, dec}))
                  ? period - dec : flr_nz;

    assign moving = (state == RUN);

    // Next-state, counter reload and ramp decisions.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        period_nxt = period;
        eff_nxt    = eff_q;
        dir_nxt    = dir;
        step       = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_one) begin
                    state_nxt  = RUN;
                    eff_nxt    = clkdiv_eff;
                    period_nxt = clkdiv_eff;
                    cnt_nxt    = clkdiv_eff - 16'd1;
                    dir_nxt    = req_right;
                end
            end
            RUN: begin
                if (!req_one || (req_right != dir)) begin
                    state_nxt  = IDLE;
                    cnt_nxt    = 16'd0;
                    period_nxt = 16'd0;
                end else if (cnt != 16'd0) begin
                    cnt_nxt = cnt - 16'd1;
                end else begin
                    step = 1'b1;
                    if (ACCEL_EN) begin
                        period_nxt = ramp;
                    end
                    cnt_nxt = period_nxt - 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, request and datapath registers.
    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state  <= IDLE;
            req_q  <= 2'b00;
            cnt    <= 16'd0;
            period <= 16'd0;
            eff_q  <= 16'd0;
            dir    <= 1'b1;
        end else begin
            state  <= state_nxt;
            req_q  <= {right, left};
            cnt    <= cnt_nxt;
            period <= period_nxt;
            eff_q  <= eff_nxt;
            dir    <= dir_nxt;
        end
    end

    quad_phase u_phase (
        .clk_sys (CLK),
        .rst_n   (Reset_n),
        .step    (step),
        .up      (dir),
        .ab      (steer)
    );

endmodule
